vehicle_sensor_conditioner: RTL and testbench

VEHICLE_SENSOR_CONDITIONER -- requirements
Module: vehicle_sensor_conditioner

---
 rtl/vehicle_sensor_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_vehicle_sensor_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_sensor_conditioner.sv
// Conditions two raw vehicle-loop detectors into debounced, fault-aware request
// lines, arrival counters and stuck-loop flags for a two-street light controller.

module vsc_street #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       loop_i,
  input  logic       green_i,
  input  logic       clr_i,
  output logic       req_o,
  output logic [7:0] count_o,
  output logic       stuck_o
);

  localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    PENDING = 2'd2,
    STUCK   = 2'd3
  } state_t;

  logic        sync1_q, sync2_q;
  logic        deb_q, deb_d;
  logic [7:0]  dcnt_q, dcnt_d;
  state_t      state_q;
  logic        served_q;
  logic [15:0] pcnt_q;
  logic        req_q, stuck_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        arrive;

  // Stage 1: synchronizer and debounce filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= loop_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync2_q != deb_q) begin
      if (dcnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 8'd1;
      end
    end
  end

  // Stage 2: occupancy FSM with registered request and fault outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      served_q <= 1'b0;
      pcnt_q   <= '0;
      req_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (deb_q) begin
            state_q  <= PRESENT;
            served_q <= 1'b0;
            pcnt_q   <= '0;
            req_q    <= 1'b1;
          end
        end
        PRESENT: begin
          if (green_i) served_q <= 1'b1;
          if (!deb_q) begin
            if (served_q || green_i) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end else begin
              state_q <= PENDING;
            end
          end else if (pcnt_q == STUCK_LAST) begin
            state_q <= STUCK;
            stuck_q <= 1'b1;
          end else begin
            pcnt_q <= pcnt_q + 16'd1;
          end
        end
        PENDING: begin
          // A returning vehicle wins over a same-cycle green, which is remembered as served
          if (deb_q) begin
            state_q  <= PRESENT;
            served_q <= green_i;
            pcnt_q   <= '0;
          end else if (green_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        STUCK: begin
          if (!deb_q) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            stuck_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          stuck_q <= 1'b0;
        end
      endcase
    end
  end

  assign arrive = deb_q && ((state_q == IDLE) || (state_q == PENDING));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (arrive && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign req_o   = req_q;
  assign stuck_o = stuck_q;
  assign count_o = cnt_q;

endmodule

module vehicle_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       loop_a,
  input  logic       loop_b,
  input  logic       GA,
  input  logic       GB,
  input  logic       clr_counts,
  output logic       sa,
  output logic       sb,
  output logic [7:0] count_a,
  output logic [7:0] count_b,
  output logic       stuck_a,
  output logic       stuck_b
);

  vsc_street #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_street_a (
    .clk    (clk),
    .rst    (reset),
    .loop_i (loop_a),
    .green_i(GA),
    .clr_i  (clr_counts),
    .req_o  (sa),
    .count_o(count_a),
    .stuck_o(stuck_a)
  );

  vsc_street #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_street_b (
    .clk    (clk),
    .rst    (reset),
    .loop_i (loop_b),
    .green_i(GB),
    .clr_i  (clr_counts),
    .req_o  (sb),
    .count_o(count_b),
    .stuck_o(stuck_b)
  );

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Table, directed and randomized checks of vehicle_sensor_conditioner against
// constants and a behavioural model of the detection rules.

module tb_vehicle_sensor_conditioner;

  localparam int DEB   = 4;
  localparam int STUCK = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       loop_a, loop_b, GA, GB, clr_counts;
  logic       sa, sb, stuck_a, stuck_b;
  logic [7:0] count_a, count_b;

  int total = 0;
  int bad   = 0;

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .STUCK_CYCLES   (STUCK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .loop_a    (loop_a),
    .loop_b    (loop_b),
    .GA        (GA),
    .GB        (GB),
    .clr_counts(clr_counts),
    .sa        (sa),
    .sb        (sb),
    .count_a   (count_a),
    .count_b   (count_b),
    .stuck_a   (stuck_a),
    .stuck_b   (stuck_b)
  );

  always #5 clk = ~clk;

  // Behavioural model: per street, a request line that tracks whether a vehicle
  // is present, waiting after leaving unserved, or a stuck loop.
  bit          m_req[2], m_left[2], m_stuck[2], m_served[2], m_deb[2];
  int          m_age[2], m_cnt[2];
  logic [15:0] m_hist[2];

  function automatic logic [19:0] pk(input bit a, input bit b, input bit c, input bit d,
                                     input logic [7:0] ca, input logic [7:0] cb);
    return {a, b, c, d, ca, cb};
  endfunction

  function automatic logic [19:0] dut_out();
    return pk(sa, sb, stuck_a, stuck_b, count_a, count_b);
  endfunction

  function automatic logic [19:0] model_out();
    return pk(m_req[0], m_req[1], m_stuck[0], m_stuck[1], 8'(m_cnt[0]), 8'(m_cnt[1]));
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_req[s] = 0; m_left[s] = 0; m_stuck[s] = 0; m_served[s] = 0; m_deb[s] = 0;
      m_age[s] = 0; m_cnt[s] = 0; m_hist[s] = '0;
    end
  endtask

  task automatic model_step(input int s, input bit raw, input bit g, input bit clr);
    bit d, arrive, flip;
    d = m_deb[s];
    arrive = 0;
    if (!m_req[s]) begin
      if (d) begin m_req[s] = 1; m_served[s] = 0; m_age[s] = 0; arrive = 1; end
    end else if (m_stuck[s]) begin
      if (!d) begin m_req[s] = 0; m_stuck[s] = 0; end
    end else if (m_left[s]) begin
      if (d) begin m_left[s] = 0; m_served[s] = g; m_age[s] = 0; arrive = 1; end
      else if (g) begin m_req[s] = 0; m_left[s] = 0; end
    end else begin
      if (g) m_served[s] = 1;
      if (!d) begin
        if (m_served[s]) m_req[s] = 0;
        else m_left[s] = 1;
      end else begin
        m_age[s]++;
        if (m_age[s] >= STUCK) m_stuck[s] = 1;
      end
    end
    if (clr) m_cnt[s] = 0;
    else if (arrive && m_cnt[s] < 255) m_cnt[s]++;
    // The filtered level flips once the last DEB synchronized samples all disagree with it
    m_hist[s] = {m_hist[s][14:0], raw};
    flip = 1;
    for (int j = 2; j <= DEB + 1; j++) if (m_hist[s][j] == d) flip = 0;
    if (flip) m_deb[s] = !d;
  endtask

  task automatic tick(input bit la, input bit lb, input bit ga, input bit gb, input bit clr);
    loop_a = la; loop_b = lb; GA = ga; GB = gb; clr_counts = clr;
    @(posedge clk);
    model_step(0, la, ga, clr);
    model_step(1, lb, gb, clr);
    #1;
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got sa/sb/sta/stb=%b cnt_a=%0d cnt_b=%0d, want sa/sb/sta/stb=%b cnt_a=%0d cnt_b=%0d",
               name, act[19:16], act[15:8], act[7:0], exp[19:16], exp[15:8], exp[7:0]);
    end
  endtask

  typedef struct {
    bit         la, lb, ga, gb, clr;
    int         n;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[14];
  int   rem[2];
  bit   lv[2];
  bit   seen;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6,  pk(0, 0, 0, 0, 8'd0, 8'd0)};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,  pk(1, 0, 0, 0, 8'd1, 8'd0)};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1,  pk(1, 0, 0, 0, 8'd1, 8'd0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6,  pk(1, 0, 0, 0, 8'd1, 8'd0)};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  pk(0, 0, 0, 0, 8'd1, 8'd0)};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7,  pk(0, 1, 0, 0, 8'd1, 8'd1)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7,  pk(0, 1, 0, 0, 8'd1, 8'd1)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1,  pk(0, 0, 0, 0, 8'd1, 8'd1)};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7,  pk(1, 0, 0, 0, 8'd2, 8'd1)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1,  pk(1, 0, 0, 0, 8'd0, 8'd0)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 62, pk(1, 0, 0, 0, 8'd0, 8'd0)};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,  pk(1, 0, 1, 0, 8'd0, 8'd0)};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6,  pk(1, 0, 1, 0, 8'd0, 8'd0)};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  pk(0, 0, 0, 0, 8'd0, 8'd0)};

    reset = 1'b1;
    loop_a = 0; loop_b = 0; GA = 0; GB = 0; clr_counts = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_out(), pk(0, 0, 0, 0, 8'd0, 8'd0));
    reset = 1'b0;

    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < tbl[r].n; c++) tick(tbl[r].la, tbl[r].lb, tbl[r].ga, tbl[r].gb, tbl[r].clr);
      check($sformatf("table_row%0d", r), dut_out(), tbl[r].exp);
    end

    seen = 0;
    for (int k = 0; k < 20; k++) begin
      repeat (3) begin tick(1, 0, 0, 0, 0); seen |= sa; end
      repeat (3) begin tick(0, 0, 0, 0, 0); seen |= sa; end
    end
    check("glitch_sa_never", {19'd0, seen}, 20'd0);
    check("glitch_count", dut_out(), pk(0, 0, 0, 0, 8'd0, 8'd0));

    for (int k = 0; k < 300; k++) begin
      repeat (8) tick(0, 1, 0, 1, 0);
      repeat (8) tick(0, 0, 0, 0, 0);
      if (k == 254) check("sat_reach_255", dut_out(), pk(0, 0, 0, 0, 8'd0, 8'd255));
    end
    check("sat_hold_255", dut_out(), pk(0, 0, 0, 0, 8'd0, 8'd255));
    tick(0, 0, 0, 0, 1);
    check("clr_counts", dut_out(), pk(0, 0, 0, 0, 8'd0, 8'd0));

    repeat (10) tick(1, 0, 0, 0, 0);
    check("pre_reset_present", dut_out(), pk(1, 0, 0, 0, 8'd1, 8'd0));
    reset = 1'b1;
    #2;
    check("async_reset", dut_out(), pk(0, 0, 0, 0, 8'd0, 8'd0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    repeat (6) tick(1, 0, 0, 0, 0);
    check("redetect_wait", dut_out(), pk(0, 0, 0, 0, 8'd0, 8'd0));
    tick(1, 0, 0, 0, 0);
    check("redetect_arrival", dut_out(), pk(1, 0, 0, 0, 8'd1, 8'd0));

    loop_a = 0; loop_b = 0; GA = 0; GB = 0; clr_counts = 0;
    reset = 1'b1;
    #2;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    lv[0] = 0; lv[1] = 0; rem[0] = 0; rem[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (rem[s] == 0) begin
          lv[s] = !lv[s];
          rem[s] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 90)) : int'($urandom_range(1, 8));
        end
        rem[s]--;
      end
      tick(lv[0], lv[1], $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
      check("random_vs_model", dut_out(), model_out());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
